// File: rtl/deser_pkg.sv
// Shared types and constants for the framed serial receiver.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package deser_pkg;

  // Word-alignment states: searching, confirming, aligned.
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

  // Bits needed to hold values 0..v-1, never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/deserializer_frame_if.sv
// Serial input plus parallel word output bundle of the framed receiver.
// Latency: n/a (wiring only).
// Backpressure: none; the receiver emits pulses the consumer must take.
interface deserializer_frame_if #(
  parameter int WIDTH = 8
) ();

  logic             din;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             locked;
  logic             sync_err;

  // Receiver side: takes the serial bit, drives words and status.
  modport master (
    input  din,
    output dout,
    output dout_valid,
    output locked,
    output sync_err
  );

  // Line/consumer side: drives the serial bit, observes words and status.
  modport slave (
    output din,
    input  dout,
    input  dout_valid,
    input  locked,
    input  sync_err
  );

endinterface

// File: rtl/deser_frame_fsm.sv
// Alignment FSM: hunts for the sync word, confirms lock, tracks frame slot and sync misses.
// Latency: sync_err registered (cycle after the word's last bit); data strobe is combinational.
// Backpressure: none; every word-complete edge is acted on immediately.
module deser_frame_fsm #(
  parameter int FRAME_LEN  = 4,
  parameter int LOCK_COUNT = 2,
  parameter int LOSS_COUNT = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_word_done,
  input  logic i_sync_match,
  output logic o_hunting,
  output logic o_data_word,
  output logic o_locked,
  output logic o_sync_err
);
  import deser_pkg::*;

  localparam int SW = clog2(FRAME_LEN);
  localparam int MW = clog2(LOCK_COUNT + 1);
  localparam int LW = clog2(LOSS_COUNT + 1);

  state_e          r_state, w_state_nxt;
  logic [SW-1:0]   r_slot_cnt, w_slot_nxt, w_slot_inc;
  logic [MW-1:0]   r_match_cnt, w_match_nxt, w_match_inc;
  logic [LW-1:0]   r_miss_cnt, w_miss_nxt, w_miss_inc;
  logic            r_sync_err, w_sync_err_nxt;
  logic            w_data_word;

  assign w_slot_inc  = (r_slot_cnt == SW'(FRAME_LEN - 1)) ? '0 : r_slot_cnt + SW'(1);
  assign w_match_inc = r_match_cnt + MW'(1);
  assign w_miss_inc  = r_miss_cnt + LW'(1);

  // Next-state and counter updates; slot 0 of every frame must carry the sync word.
  always_comb begin
    w_state_nxt    = r_state;
    w_slot_nxt     = r_slot_cnt;
    w_match_nxt    = r_match_cnt;
    w_miss_nxt     = r_miss_cnt;
    w_sync_err_nxt = 1'b0;
    w_data_word    = 1'b0;
    case (r_state)
      HUNT: begin
        // Window just matched: the next bit starts the word in slot 1.
        if (i_sync_match) begin
          w_state_nxt = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
          w_slot_nxt  = SW'(1);
          w_match_nxt = MW'(1);
          w_miss_nxt  = '0;
        end
      end
      VERIFY: begin
        if (i_word_done) begin
          w_slot_nxt = w_slot_inc;
          if (r_slot_cnt == '0) begin
            if (i_sync_match) begin
              w_match_nxt = w_match_inc;
              if (w_match_inc == MW'(LOCK_COUNT)) begin
                w_state_nxt = LOCKED;
                w_miss_nxt  = '0;
              end
            end else begin
              w_state_nxt = HUNT;
              w_match_nxt = '0;
              w_slot_nxt  = '0;
            end
          end
        end
      end
      LOCKED: begin
        if (i_word_done) begin
          w_slot_nxt = w_slot_inc;
          if (r_slot_cnt != '0) begin
            w_data_word = 1'b1;
          end else if (i_sync_match) begin
            w_miss_nxt = '0;
          end else begin
            // Missed sync keeps the current word phase unless misses run out.
            w_sync_err_nxt = 1'b1;
            w_miss_nxt     = w_miss_inc;
            if (w_miss_inc == LW'(LOSS_COUNT)) begin
              w_state_nxt = HUNT;
              w_miss_nxt  = '0;
              w_match_nxt = '0;
              w_slot_nxt  = '0;
            end
          end
        end
      end
      default: begin
        w_state_nxt = HUNT;
      end
    endcase
  end

  // State, counters and the sync-error pulse register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= HUNT;
      r_slot_cnt  <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_sync_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_slot_cnt  <= w_slot_nxt;
      r_match_cnt <= w_match_nxt;
      r_miss_cnt  <= w_miss_nxt;
      r_sync_err  <= w_sync_err_nxt;
    end
  end

  assign o_hunting   = (r_state == HUNT);
  assign o_locked    = (r_state == LOCKED);
  assign o_sync_err  = r_sync_err;
  assign o_data_word = w_data_word;

endmodule

// File: rtl/deserializer_frame.sv
// Framed LSB-first serial-to-parallel receiver with sync-word alignment and loss detection.
// Latency: dout/dout_valid/sync_err appear the cycle after the edge sampling a word's last bit.
// Backpressure: none; dout_valid is a single-cycle pulse that cannot be stalled.
module deserializer_frame #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD  = deser_pkg::DEFAULT_SYNC_WORD,
  parameter int               FRAME_LEN  = 4,
  parameter int               LOCK_COUNT = 2,
  parameter int               LOSS_COUNT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  deserializer_frame_if.master  bus
);
  import deser_pkg::*;

  localparam int BW = clog2(WIDTH);

  // Only the WIDTH-1 previous bits are stored; the live din completes the window.
  logic [WIDTH-2:0] r_sr;
  logic [WIDTH-1:0] w_window;
  logic [BW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             w_word_done;
  logic             w_sync_match;
  logic             w_hunting;
  logic             w_data_word;
  logic             w_locked;
  logic             w_sync_err;

  assign w_window     = {bus.din, r_sr};
  assign w_sync_match = (w_window == SYNC_WORD);
  // While hunting the bit counter is meaningless; words only complete once aligned.
  assign w_word_done  = !w_hunting && (r_bit_cnt == BW'(WIDTH - 1));

  // Shift register and bit counter; the counter is held at 0 while hunting so the
  // word after a detected sync starts cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_sr <= w_window[WIDTH-1:1];
      if (w_hunting || w_word_done) r_bit_cnt <= '0;
      else                          r_bit_cnt <= r_bit_cnt + BW'(1);
    end
  end

  // Output word register: captured only for data slots while locked, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_data_word;
      if (w_data_word) r_dout <= w_window;
    end
  end

  deser_frame_fsm #(
    .FRAME_LEN  (FRAME_LEN),
    .LOCK_COUNT (LOCK_COUNT),
    .LOSS_COUNT (LOSS_COUNT)
  ) u_fsm (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_word_done  (w_word_done),
    .i_sync_match (w_sync_match),
    .o_hunting    (w_hunting),
    .o_data_word  (w_data_word),
    .o_locked     (w_locked),
    .o_sync_err   (w_sync_err)
  );

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.locked     = w_locked;
  assign bus.sync_err   = w_sync_err;

endmodule

// File: tb/tb_deserializer_frame.sv
// Self-checking bench for deserializer_frame: per-word vector table plus data scoreboard.
// Latency: outputs sampled 1 time unit after the edge of each word's last bit.
// Backpressure: n/a.
module tb_deserializer_frame;

  logic clk;
  logic rst;

  deserializer_frame_if #(.WIDTH(8)) bus ();

  deserializer_frame dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One serial word plus the status expected right after its last bit.
  typedef struct {
    logic [7:0] word;
    logic       exp_locked;
    logic       exp_err;
    logic       exp_vld;
  } rec_t;

  rec_t       tab[$];
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int         checks   = 0;
  int         failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.din = b;
    @(posedge clk);
    #1;
  endtask

  // A frame: sync slot then data 11,22,33; data is delivered only when locked.
  task automatic add_frame(input logic [7:0] s, input logic lk, input logic err);
    tab.push_back(rec_t'{s,     lk, err,  1'b0});
    tab.push_back(rec_t'{8'h11, lk, 1'b0, lk});
    tab.push_back(rec_t'{8'h22, lk, 1'b0, lk});
    tab.push_back(rec_t'{8'h33, lk, 1'b0, lk});
  endtask

  task automatic send_rec(input rec_t r);
    logic quiet;
    quiet = 1'b1;
    if (r.exp_vld) exp_q.push_back(r.word);
    for (int i = 0; i < 8; i++) begin
      send_bit(r.word[i]);
      if (i < 7 && (bus.dout_valid || bus.sync_err)) quiet = 1'b0;
    end
    chk($sformatf("midword_quiet_%02h", r.word), quiet, 1);
    chk($sformatf("locked_%02h", r.word), bus.locked, r.exp_locked);
    chk($sformatf("sync_err_%02h", r.word), bus.sync_err, r.exp_err);
    chk($sformatf("dout_valid_%02h", r.word), bus.dout_valid, r.exp_vld);
  endtask

  task automatic run_tab();
    for (int i = 0; i < tab.size(); i++) send_rec(tab[i]);
    tab.delete();
  endtask

  task automatic do_reset(input int cycles);
    rst     = 1'b1;
    bus.din = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard: every dout_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (bus.dout_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: dout=%0h with no word expected (t=%0t)", bus.dout, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("dout_data", bus.dout, mon_exp);
      end
    end
  end

  initial begin
    logic [12:0] s;
    logic        early;
    logic [7:0]  w22;

    // Reset state
    rst     = 1'b1;
    bus.din = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dout", bus.dout, 0);
    chk("reset_dout_valid", bus.dout_valid, 0);
    chk("reset_locked", bus.locked, 0);
    chk("reset_sync_err", bus.sync_err, 0);
    rst = 1'b0;

    // Clean lock, single miss, double miss (loss), relock
    repeat (3) send_bit(1'b0);
    add_frame(8'hA5, 1'b0, 1'b0);
    add_frame(8'hA5, 1'b1, 1'b0);
    add_frame(8'hA4, 1'b1, 1'b1);
    add_frame(8'hA5, 1'b1, 1'b0);
    add_frame(8'hA4, 1'b1, 1'b1);
    add_frame(8'hA4, 1'b0, 1'b1);
    run_tab();
    chk("hold_dout_after_loss", bus.dout, 8'h33);
    add_frame(8'hA5, 1'b0, 1'b0);
    run_tab();
    chk("hold_dout_in_verify", bus.dout, 8'h33);
    add_frame(8'hA5, 1'b1, 1'b0);
    run_tab();

    // Unaligned start: 5 random bits that never form an early sync match
    do begin
      s     = {8'hA5, 5'($urandom)};
      early = 1'b0;
      for (int j = 7; j < 12; j++) if (s[j-7 +: 8] == 8'hA5) early = 1'b1;
    end while (early);
    do_reset(1);
    for (int i = 0; i < 5; i++) send_bit(s[i]);
    add_frame(8'hA5, 1'b0, 1'b0);
    add_frame(8'hA5, 1'b1, 1'b0);
    run_tab();

    // False sync while verifying: 0x5A in slot 0 sends it back to hunting
    do_reset(1);
    add_frame(8'hA5, 1'b0, 1'b0);
    add_frame(8'h5A, 1'b0, 1'b0);
    add_frame(8'hA5, 1'b0, 1'b0);
    add_frame(8'hA5, 1'b1, 1'b0);
    run_tab();

    // Reset halfway through data word 0x22 while locked
    do_reset(1);
    add_frame(8'hA5, 1'b0, 1'b0);
    add_frame(8'hA5, 1'b1, 1'b0);
    tab.push_back(rec_t'{8'hA5, 1'b1, 1'b0, 1'b0});
    tab.push_back(rec_t'{8'h11, 1'b1, 1'b0, 1'b1});
    run_tab();
    w22 = 8'h22;
    for (int i = 0; i < 4; i++) send_bit(w22[i]);
    rst     = 1'b1;
    bus.din = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midreset_dout", bus.dout, 0);
    chk("midreset_dout_valid", bus.dout_valid, 0);
    chk("midreset_locked", bus.locked, 0);
    chk("midreset_sync_err", bus.sync_err, 0);
    add_frame(8'hA5, 1'b0, 1'b0);
    add_frame(8'hA5, 1'b1, 1'b0);
    run_tab();

    repeat (4) send_bit(1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
